// File: rtl/llc_cmd_dispatch_pkg.sv
// Shared definitions for the LLC trace-command dispatcher.
// Provides address/command widths, the trace command encoding, the
// buffered command payload, dispatcher FSM states and the command decoder.
package line;

    localparam int unsigned ADDR_SIZE = 32;
    localparam int unsigned CMD_W     = 4;

    typedef enum logic [CMD_W-1:0] {
        RD_DATA = 4'd0,
        WR_DATA = 4'd1,
        RD_INST = 4'd2,
        SN_INV  = 4'd3,
        SN_RD   = 4'd4,
        SN_WR   = 4'd5,
        SN_RWIM = 4'd6,
        CLEAR   = 4'd8,
        PRINT   = 4'd9
    } cmd_e;

    // Code is kept as raw bits so illegal codes survive buffering and can be flagged.
    typedef struct packed {
        logic [CMD_W-1:0]     code;
        logic [ADDR_SIZE-1:0] addr;
    } cmd_st;

    typedef enum logic {
        RUN      = 1'b0,
        CLR_WAIT = 1'b1
    } dispatch_state_e;

    // One-hot request selection plus the snoop qualifier.
    typedef struct packed {
        logic rd;
        logic wr;
        logic inv;
        logic snp;
        logic clr;
        logic prt;
        logic bad;
    } req_st;

    // Map a trace code onto the request it issues to the cache.
    function automatic req_st decode_cmd(input logic [CMD_W-1:0] code);
        req_st r;
        r = '0;
        case (code)
            RD_DATA, RD_INST: r.rd = 1'b1;
            WR_DATA:          r.wr = 1'b1;
            SN_INV, SN_RWIM:  begin r.inv = 1'b1; r.snp = 1'b1; end
            SN_RD:            begin r.rd  = 1'b1; r.snp = 1'b1; end
            SN_WR:            begin r.wr  = 1'b1; r.snp = 1'b1; end
            CLEAR:            r.clr = 1'b1;
            PRINT:            r.prt = 1'b1;
            default:          r.bad = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/llc_cmd_dispatch_if.sv
// Handshake and cache-request bundle of the LLC command dispatcher.
// master: trace source / cache side (drives commands and cache_busy).
// slave : the dispatcher (accepts commands, drives request pulses).
//   cmd_valid/cmd_ready/cmd_code/cmd_addr : trace command handshake
//   cache_busy                            : cache stall
//   address, read_req, write_req, invalidate, snoop,
//   clear_req, print_req, bad_cmd         : issued request and pulses
interface llc_cmd_dispatch_if;
    import line::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CMD_W-1:0]     cmd_code;
    logic [ADDR_SIZE-1:0] cmd_addr;
    logic                 cache_busy;
    logic [ADDR_SIZE-1:0] address;
    logic                 read_req;
    logic                 write_req;
    logic                 invalidate;
    logic                 snoop;
    logic                 clear_req;
    logic                 print_req;
    logic                 bad_cmd;

    modport master (
        output cmd_valid, cmd_code, cmd_addr, cache_busy,
        input  cmd_ready, address, read_req, write_req, invalidate,
               snoop, clear_req, print_req, bad_cmd
    );

    modport slave (
        input  cmd_valid, cmd_code, cmd_addr, cache_busy,
        output cmd_ready, address, read_req, write_req, invalidate,
               snoop, clear_req, print_req, bad_cmd
    );

endinterface

// File: rtl/llc_cmd_dispatch_cmd_fifo.sv
// cmd_fifo: synchronous FIFO of cmd_st entries with registered full/empty.
//   clk, rst  : clock, asynchronous active-low reset
//   i_push    : write i_data (ignored when full)
//   i_pop     : drop the head entry (ignored when empty)
//   o_head_c  : head entry, combinational read of the storage
//   o_full    : count == DEPTH
//   o_empty   : count == 0
module cmd_fifo
    import line::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_push,
    input  cmd_st i_data,
    input  logic  i_pop,
    output cmd_st o_head_c,
    output logic  o_full,
    output logic  o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    cmd_st            r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    // Occupancy after this edge; flags are registered from it.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage needs no reset; contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_head_c = r_mem[r_rd_ptr];
    assign o_full   = r_full;
    assign o_empty  = r_empty;

endmodule

// File: rtl/llc_cmd_dispatch.sv
// llc_cmd_dispatch: buffers trace commands and issues them to the cache as
// single-cycle request pulses, sequencing clear (with a stall window) and print.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : llc_cmd_dispatch_if.slave (command handshake, cache_busy, pulses)
// Optional build macro DISPATCH_STATS_EN adds 16-bit saturating counters
//   rd_cnt, wr_cnt, inv_cnt, bad_cnt (cleared by reset and by a clear issue).
module llc_cmd_dispatch
    import line::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLEAR_WAIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    llc_cmd_dispatch_if.slave   bus
`ifdef DISPATCH_STATS_EN
    ,
    output logic [15:0]         rd_cnt,
    output logic [15:0]         wr_cnt,
    output logic [15:0]         inv_cnt,
    output logic [15:0]         bad_cnt
`endif
);

    localparam int unsigned CNT_W = (CLEAR_WAIT > 0) ? $clog2(CLEAR_WAIT + 1) : 1;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    cmd_st                w_wr_data;
    cmd_st                w_head;
    req_st                w_dec;

    dispatch_state_e      r_state;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic [ADDR_SIZE-1:0] r_address;
    logic                 r_read_req;
    logic                 r_write_req;
    logic                 r_invalidate;
    logic                 r_snoop;
    logic                 r_clear_req;
    logic                 r_print_req;
    logic                 r_bad_cmd;

    // No push when full, even if the head pops on the same edge.
    assign w_push    = bus.cmd_valid && !w_full;
    assign w_pop     = (r_state == RUN) && !w_empty && !bus.cache_busy;
    assign w_wr_data = cmd_st'{code: bus.cmd_code, addr: bus.cmd_addr};
    assign w_dec     = decode_cmd(w_head.code);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .i_data   (w_wr_data),
        .i_pop    (w_pop),
        .o_head_c (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    // Issue FSM: pulses default low so each lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= RUN;
            r_wait_cnt   <= '0;
            r_address    <= '0;
            r_read_req   <= 1'b0;
            r_write_req  <= 1'b0;
            r_invalidate <= 1'b0;
            r_snoop      <= 1'b0;
            r_clear_req  <= 1'b0;
            r_print_req  <= 1'b0;
            r_bad_cmd    <= 1'b0;
        end else begin
            r_read_req   <= 1'b0;
            r_write_req  <= 1'b0;
            r_invalidate <= 1'b0;
            r_snoop      <= 1'b0;
            r_clear_req  <= 1'b0;
            r_print_req  <= 1'b0;
            r_bad_cmd    <= 1'b0;
            case (r_state)
                RUN: begin
                    if (w_pop) begin
                        r_read_req   <= w_dec.rd;
                        r_write_req  <= w_dec.wr;
                        r_invalidate <= w_dec.inv;
                        r_snoop      <= w_dec.snp;
                        r_clear_req  <= w_dec.clr;
                        r_print_req  <= w_dec.prt;
                        r_bad_cmd    <= w_dec.bad;
                        r_address    <= w_head.addr;
                        if (w_dec.clr) begin
                            r_state    <= CLR_WAIT;
                            r_wait_cnt <= CNT_W'(CLEAR_WAIT);
                        end
                    end
                end
                CLR_WAIT: begin
                    // Return to RUN on the edge the counter lands on zero.
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    end
                    if (r_wait_cnt <= CNT_W'(1)) begin
                        r_state <= RUN;
                    end
                end
            endcase
        end
    end

    assign bus.cmd_ready  = !w_full;
    assign bus.address    = r_address;
    assign bus.read_req   = r_read_req;
    assign bus.write_req  = r_write_req;
    assign bus.invalidate = r_invalidate;
    assign bus.snoop      = r_snoop;
    assign bus.clear_req  = r_clear_req;
    assign bus.print_req  = r_print_req;
    assign bus.bad_cmd    = r_bad_cmd;

`ifdef DISPATCH_STATS_EN
    localparam int unsigned STAT_W = 16;

    logic [STAT_W-1:0] r_rd_cnt;
    logic [STAT_W-1:0] r_wr_cnt;
    logic [STAT_W-1:0] r_inv_cnt;
    logic [STAT_W-1:0] r_bad_cnt;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + STAT_W'(1) : v;
    endfunction

    // Counters step on the issue edge, so they track the pulses one-for-one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_inv_cnt <= '0;
            r_bad_cnt <= '0;
        end else if (w_pop && w_dec.clr) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_inv_cnt <= '0;
            r_bad_cnt <= '0;
        end else if (w_pop) begin
            r_rd_cnt  <= sat_inc(r_rd_cnt,  w_dec.rd);
            r_wr_cnt  <= sat_inc(r_wr_cnt,  w_dec.wr);
            r_inv_cnt <= sat_inc(r_inv_cnt, w_dec.inv);
            r_bad_cnt <= sat_inc(r_bad_cnt, w_dec.bad);
        end
    end

    assign rd_cnt  = r_rd_cnt;
    assign wr_cnt  = r_wr_cnt;
    assign inv_cnt = r_inv_cnt;
    assign bad_cnt = r_bad_cnt;
`endif

endmodule

// File: tb/tb_llc_cmd_dispatch.sv
// Scoreboard bench for llc_cmd_dispatch: stimulus pushes expected pulses
// into a queue, a negedge monitor pops and compares whenever a pulse appears.
module tb_llc_cmd_dispatch;
    import line::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    llc_cmd_dispatch_if bus ();

`ifdef DISPATCH_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, inv_cnt, bad_cnt;
`endif

    llc_cmd_dispatch #(
        .FIFO_DEPTH (4),
        .CLEAR_WAIT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DISPATCH_STATS_EN
        ,
        .rd_cnt  (rd_cnt),
        .wr_cnt  (wr_cnt),
        .inv_cnt (inv_cnt),
        .bad_cnt (bad_cnt)
`endif
    );

    // Pulse vector order: {read, write, invalidate, snoop, clear, print, bad}
    localparam logic [6:0] P_RD   = 7'b1000000;
    localparam logic [6:0] P_WR   = 7'b0100000;
    localparam logic [6:0] P_SINV = 7'b0011000;
    localparam logic [6:0] P_SRD  = 7'b1001000;
    localparam logic [6:0] P_SWR  = 7'b0101000;
    localparam logic [6:0] P_CLR  = 7'b0000100;
    localparam logic [6:0] P_PRT  = 7'b0000010;
    localparam logic [6:0] P_BAD  = 7'b0000001;

    typedef struct {
        logic [6:0]  pat;
        logic [31:0] addr;
        int          cyc;   // -1: any cycle
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pulse_cnt = 0;

    wire [6:0] obs = {bus.read_req, bus.write_req, bus.invalidate, bus.snoop,
                      bus.clear_req, bus.print_req, bus.bad_cmd};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle with any pulse consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && obs != 7'b0) begin
            pulse_cnt++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got pulses=%b addr=%h cyc=%0d, required no pulse",
                         obs, bus.address, cyc);
            end else begin
                e = q.pop_front();
                if (obs !== e.pat || bus.address !== e.addr || (e.cyc >= 0 && cyc != e.cyc)) begin
                    bad++;
                    $display("FAIL pulse_check: got pulses=%b addr=%h cyc=%0d, required pulses=%b addr=%h cyc=%0d",
                             obs, bus.address, cyc, e.pat, e.addr, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Called at a negedge; push lands on the next posedge.
    task automatic push_cmd(input logic [3:0] code, input logic [31:0] addr,
                            input logic [6:0] pat, input bit track, input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL push_timeout: cmd_ready got %b, required 1", bus.cmd_ready);
        end else begin
            bus.cmd_valid = 1'b1;
            bus.cmd_code  = code;
            bus.cmd_addr  = addr;
            if (track) begin
                e.pat  = pat;
                e.addr = addr;
                e.cyc  = (lat < 0) ? -1 : cyc + lat;
                q.push_back(e);
            end
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending pulses, required 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_code   = '0;
        bus.cmd_addr   = '0;
        bus.cache_busy = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("reset_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset_pulses", 32'(obs), 32'd0);
        check("reset_address", bus.address, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single read into empty FIFO: pulse two edges after the push.
        push_cmd(4'd0, 32'h0000_1040, P_RD, 1'b1, 2);
        drain();
        check("pulse_one_cycle", 32'(obs), 32'd0);
        check("address_hold", bus.address, 32'h0000_1040);

        // Back-to-back codes give back-to-back pulses.
        push_cmd(4'd1, 32'h0000_0100, P_WR,   1'b1, 2);
        push_cmd(4'd3, 32'h0000_0200, P_SINV, 1'b1, 2);
        push_cmd(4'd4, 32'h0000_0300, P_SRD,  1'b1, 2);
        push_cmd(4'd2, 32'h0000_0400, P_RD,   1'b1, 2);
        push_cmd(4'd5, 32'h0000_0500, P_SWR,  1'b1, 2);
        push_cmd(4'd6, 32'h0000_0600, P_SINV, 1'b1, 2);
        push_cmd(4'd9, 32'h0000_0700, P_PRT,  1'b1, 2);
        drain();

        // Busy: fill the FIFO, no pulses, then release and drain in order.
        bus.cache_busy = 1'b1;
        pc = pulse_cnt;
        push_cmd(4'd1, 32'h0000_1000, P_WR,   1'b1, -1);
        push_cmd(4'd2, 32'h0000_2000, P_RD,   1'b1, -1);
        push_cmd(4'd5, 32'h0000_3000, P_SWR,  1'b1, -1);
        push_cmd(4'd6, 32'h0000_4000, P_SINV, 1'b1, -1);
        check("full_ready_low", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_code  = 4'd9;
        bus.cmd_addr  = 32'h0000_5000;
        repeat (2) @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("full_ready_still_low", 32'(bus.cmd_ready), 32'd0);
        check("busy_no_pulse", 32'(pulse_cnt), 32'(pc));
        for (int i = 0; i < q.size(); i++) q[i].cyc = cyc + 1 + i;
        bus.cache_busy = 1'b0;
        drain();
        check("drained_ready", 32'(bus.cmd_ready), 32'd1);
        check("busy_addr_hold", bus.address, 32'h0000_4000);

        // Clear: one clear pulse, eight idle cycles, then the read.
        push_cmd(4'd8, 32'h0000_C000, P_CLR, 1'b1, 2);
        push_cmd(4'd0, 32'h0000_C040, P_RD,  1'b1, 10);
        drain();

        // Illegal code is dropped with a bad_cmd pulse only.
        push_cmd(4'd7, 32'h0000_BAD0, P_BAD, 1'b1, 2);
        drain();
        check("bad_addr_update", bus.address, 32'h0000_BAD0);
`ifdef DISPATCH_STATS_EN
        check("stat_bad_cnt", 32'(bad_cnt), 32'd1);
        check("stat_rd_cnt", 32'(rd_cnt), 32'd1);
        check("stat_wr_cnt", 32'(wr_cnt), 32'd0);
        check("stat_inv_cnt", 32'(inv_cnt), 32'd0);
`endif

        // Reset in the middle of the clear wait with three entries queued.
        push_cmd(4'd8, 32'hDEAD_0000, P_CLR, 1'b1, 2);
        push_cmd(4'd0, 32'h0000_0010, P_RD, 1'b0, -1);
        push_cmd(4'd1, 32'h0000_0020, P_WR, 1'b0, -1);
        push_cmd(4'd2, 32'h0000_0030, P_RD, 1'b0, -1);
        repeat (2) @(negedge clk);
        check("clear_seen", 32'(q.size()), 32'd0);
        check("pre_reset_address", bus.address, 32'hDEAD_0000);
        #2 rst = 1'b0;
        #1;
        check("async_rst_address", bus.address, 32'h0);
        check("async_rst_pulses", 32'(obs), 32'd0);
        check("async_rst_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        pc = pulse_cnt;
        repeat (20) @(negedge clk);
        check("post_reset_no_pulse", 32'(pulse_cnt), 32'(pc));
`ifdef DISPATCH_STATS_EN
        check("post_reset_bad_cnt", 32'(bad_cnt), 32'd0);
`endif
        // FIFO must be empty: the next push is the first thing issued.
        push_cmd(4'd9, 32'h0000_9000, P_PRT, 1'b1, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/llc_cmd_dispatch.md
# llc_cmd_dispatch

Upstream feeder for the `cache` block. It accepts trace commands (operation code plus address) over a valid/ready handshake and buffers them in a small FIFO. Each command is decoded and issued to the cache as a single-cycle request pulse (`read_req`, `write_req`, `invalidate`) with the matching address. Clear and print commands are sequenced here, so the cache only ever sees one well-formed request per cycle.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: command buffer entries; power of two, 2..16.
- `CLEAR_WAIT`, 8: stall cycles after a clear command issues.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  trace command present.
- `cmd_ready`  out  1  buffer can accept; equals `!full`.
- `cmd_code`  in  `CMD_W`(4)  trace operation, `cmd_e`.
- `cmd_addr`  in  `ADDR_SIZE`  trace address.
- `cache_busy`  in  1  cache stall; no issue while high.
- `address`  out  `ADDR_SIZE`  address of the issued request.
- `read_req`, `write_req`, `invalidate`  out  1 each  request pulses to the cache.
- `snoop`  out  1  qualifies the current pulse as snoop-originated.
- `clear_req`  out  1  cache clear/reset pulse.
- `print_req`  out  1  contents-dump pulse.
- `bad_cmd`  out  1  pulse when an illegal code is dropped.

## Operation
- Push on the rising edge where `cmd_valid && cmd_ready`. There is no push when full, even if a pop happens in the same cycle.
- Decode, applied at pop:
  - 0 (data read) and 2 (instruction read) -> `read_req`.
  - 1 (data write) -> `write_req`.
  - 3 (snoop invalidate) and 6 (snoop RWIM) -> `invalidate` + `snoop`.
  - 4 (snoop read) -> `read_req` + `snoop`.
  - 5 (snoop write) -> `write_req` + `snoop`.
  - 8 -> `clear_req`.
  - 9 -> `print_req`.
  - 7, 10-15 -> `bad_cmd`; nothing else asserted.
- FSM has two states:
  - RUN: pop the head on an edge where FIFO is non-empty and `cache_busy` is low.
  - CLR_WAIT: no pops; a down-counter (width `$clog2(CLEAR_WAIT+1)`) loaded with `CLEAR_WAIT` decrements each cycle. RUN resumes on the edge the counter reaches 0.
- RUN -> CLR_WAIT when the popped entry is code 8.
- Pushes remain legal in CLR_WAIT.
- At most one of `read_req`/`write_req`/`invalidate`/`clear_req`/`print_req`/`bad_cmd` is high in any cycle.
- `address` holds the last issued value between pulses. It also updates for codes 8, 9 and illegal codes.

## Timing
- All outputs are registered. Reset values: all request/pulse outputs 0, `address` 0, `cmd_ready` 1, FIFO empty, state RUN, counter 0.
- Latency: push at edge k into an empty FIFO -> pulse high from edge k+1 to edge k+2. There is no same-cycle bypass.
- Throughput: one issue per cycle while `cache_busy` is low.
- `cache_busy` is sampled at the pop edge. If it is high, no pop occurs and all pulses are 0 the next cycle.
- Every pulse lasts exactly one cycle. Back-to-back pops give back-to-back pulses.
- FIFO pointers wrap modulo `FIFO_DEPTH`. A count of `FIFO_DEPTH` means full; 0 means empty.
- Reset asserted mid-operation:
  - FIFO contents are discarded.
  - The clear wait is aborted.
  - All outputs go to reset values immediately, without waiting for a clock edge.

## Configuration
- `DISPATCH_STATS_EN`: when defined, adds four 16-bit saturating counters as output ports: `rd_cnt`, `wr_cnt`, `inv_cnt`, `bad_cnt`.
- The counters increment on the same edge as the corresponding pulse.
- Snoop requests are counted too.
- The counters reset to 0 on `rst` and on a `clear_req` issue. They hold at 0xFFFF once saturated.
- When the macro is undefined, neither the ports nor the logic exist.

## Structure
- Shared package `line` gains:
  - `CMD_W` = 4.
  - `cmd_e` enum: `RD_DATA`=0, `WR_DATA`=1, `RD_INST`=2, `SN_INV`=3, `SN_RD`=4, `SN_WR`=5, `SN_RWIM`=6, `CLEAR`=8, `PRINT`=9.
  - `cmd_st` struct: code, addr.
  - `dispatch_state_e` enum: RUN, CLR_WAIT.
- The block uses `ADDR_SIZE` from the same package.
- One sub-module, `cmd_fifo`: a synchronous `cmd_st` FIFO with push, pop, full and empty. It uses the same clock and reset.

## Test plan
- Reset, then push code 0 at address 0x0000_1040 into an empty FIFO -> `read_req`=1, `snoop`=0, `address`=0x0000_1040 exactly one cycle, two edges after the push.
- Push codes 1, 3, 4 back-to-back with `cache_busy`=0 -> consecutive one-cycle pulses:
  - `write_req`;
  - `invalidate`+`snoop`;
  - `read_req`+`snoop`.
- Hold `cache_busy`=1 and push 5 commands with `FIFO_DEPTH`=4 -> `cmd_ready` drops after the 4th push and no pulses occur. Release `cache_busy` -> 4 pulses in order, then `cmd_ready`=1.
- Push code 8 followed by code 0 -> one-cycle `clear_req`, then exactly `CLEAR_WAIT`=8 idle cycles, then `read_req`.
- Push code 7 -> one-cycle `bad_cmd`, no request pulse. With `DISPATCH_STATS_EN` defined, `bad_cnt`=1.
- Assert `rst` low mid-clear-wait with 3 entries queued -> outputs 0 immediately. After release the FIFO is empty and no pulses occur.
